// File: rtl/chip8_display_pkg.sv
// Shared state encoding and display geometry for the CHIP-8 sprite draw engine.
package chip8_display_pkg;

    localparam int FB_W     = 32'd64;
    localparam int FB_H     = 32'd32;
    localparam int FB_BYTES = 32'd256;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SPR_RD  = 3'd1,
        ST_FB_RD_L = 3'd2,
        ST_FB_WR_L = 3'd3,
        ST_FB_RD_R = 3'd4,
        ST_FB_WR_R = 3'd5,
        ST_CLEAR   = 3'd6,
        ST_DONE    = 3'd7
    } draw_state_e;

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Command, sprite-memory and framebuffer ports of the sprite draw engine.
interface sprite_draw_engine_if #(
    parameter int MEM_AW = 12,
    parameter int FB_AW  = 8
);
    logic              cmd_valid_in;
    logic              cmd_ready_out;
    logic              cmd_op_in;
    logic [7:0]        x_in;
    logic [7:0]        y_in;
    logic [3:0]        n_in;
    logic [MEM_AW-1:0] sprite_addr_in;
    logic [MEM_AW-1:0] mem_addr_out;
    logic              mem_rd_out;
    logic [7:0]        mem_data_in;
    logic [FB_AW-1:0]  fb_addr_out;
    logic              fb_rd_out;
    logic [7:0]        fb_data_in;
    logic              fb_we_out;
    logic [7:0]        fb_wdata_out;
    logic              done_out;
    logic              collision_out;

    modport slave (
        input  cmd_valid_in, cmd_op_in, x_in, y_in, n_in, sprite_addr_in,
               mem_data_in, fb_data_in,
        output cmd_ready_out, mem_addr_out, mem_rd_out, fb_addr_out, fb_rd_out,
               fb_we_out, fb_wdata_out, done_out, collision_out
    );

    modport master (
        output cmd_valid_in, cmd_op_in, x_in, y_in, n_in, sprite_addr_in,
               mem_data_in, fb_data_in,
        input  cmd_ready_out, mem_addr_out, mem_rd_out, fb_addr_out, fb_rd_out,
               fb_we_out, fb_wdata_out, done_out, collision_out
    );
endinterface

// File: rtl/sprite_draw_engine_aligner.sv
// Splits one sprite byte across the two framebuffer bytes it may straddle.
module sprite_aligner (
    input  logic [7:0] sprite,
    input  logic [2:0] offset,
    input  logic [2:0] byte_col,
    output logic [7:0] mask_l,
    output logic [7:0] mask_r,
    output logic       straddle
);
    logic [15:0] spread_s;

    // Shift the byte into a 16-bit window: upper half is the left byte, lower half the right.
    always_comb begin
        spread_s = {sprite, 8'h00} >> offset;
        mask_l   = spread_s[15:8];
        mask_r   = spread_s[7:0];
        straddle = (offset != 3'd0) && (byte_col != 3'd7);
    end
endmodule

// File: rtl/sprite_draw_engine.sv
// CHIP-8 DXYN sprite XOR-draw and screen-clear engine over byte-wide framebuffer RAM.
module sprite_draw_engine
    import chip8_display_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int FB_AW  = 8
) (
    input  logic clk_in,
    input  logic rst_n_in,
    sprite_draw_engine_if.slave bus
);
    draw_state_e       state_r;
    draw_state_e       state_nxt_s;
    draw_state_e       row_end_s;
    logic [5:0]        x0_r;
    logic [4:0]        y_r;
    logic [3:0]        n_r;
    logic [3:0]        row_r;
    logic [MEM_AW-1:0] addr_r;
    logic [7:0]        s_r;
    logic [7:0]        clr_r;
    logic              collision_r;
    logic [7:0]        mask_l_s;
    logic [7:0]        mask_r_s;
    logic              straddle_s;
    logic              accept_s;
    logic              hit_l_s;
    logic              hit_r_s;

    sprite_aligner u_aligner (
        .sprite   (s_r),
        .offset   (x0_r[2:0]),
        .byte_col (x0_r[5:3]),
        .mask_l   (mask_l_s),
        .mask_r   (mask_r_s),
        .straddle (straddle_s)
    );

    // Next-state logic; a row ends early once the bottom screen line has been drawn.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && bus.cmd_valid_in;
        hit_l_s  = |(bus.fb_data_in & mask_l_s);
        hit_r_s  = |(bus.fb_data_in & mask_r_s);
        if ((row_r + 4'd1 == n_r) || (y_r == 5'd31)) begin
            row_end_s = ST_DONE;
        end else begin
            row_end_s = ST_SPR_RD;
        end
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!bus.cmd_valid_in) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.cmd_op_in) begin
                    state_nxt_s = ST_CLEAR;
                end else if (bus.n_in == 4'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SPR_RD;
                end
            end
            ST_SPR_RD:  state_nxt_s = ST_FB_RD_L;
            ST_FB_RD_L: state_nxt_s = ST_FB_WR_L;
            ST_FB_WR_L: begin
                if (straddle_s) begin
                    state_nxt_s = ST_FB_RD_R;
                end else begin
                    state_nxt_s = row_end_s;
                end
            end
            ST_FB_RD_R: state_nxt_s = ST_FB_WR_R;
            ST_FB_WR_R: state_nxt_s = row_end_s;
            ST_CLEAR: begin
                if (clr_r == 8'hFF) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_DONE:    state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State, latched command, sprite byte capture, row advance and collision flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r     <= ST_IDLE;
            x0_r        <= 6'd0;
            y_r         <= 5'd0;
            n_r         <= 4'd0;
            row_r       <= 4'd0;
            addr_r      <= {MEM_AW{1'b0}};
            s_r         <= 8'd0;
            clr_r       <= 8'd0;
            collision_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                x0_r        <= bus.x_in[5:0];
                y_r         <= bus.y_in[4:0];
                n_r         <= bus.n_in;
                row_r       <= 4'd0;
                addr_r      <= bus.sprite_addr_in;
                clr_r       <= 8'd0;
                collision_r <= 1'b0;
            end
            if (state_r == ST_FB_RD_L) begin
                s_r <= bus.mem_data_in;
            end
            if (state_r == ST_CLEAR) begin
                clr_r <= clr_r + 8'd1;
            end
            if (((state_r == ST_FB_WR_L) && hit_l_s) || ((state_r == ST_FB_WR_R) && hit_r_s)) begin
                collision_r <= 1'b1;
            end
            if (((state_r == ST_FB_WR_L) && !straddle_s) || (state_r == ST_FB_WR_R)) begin
                row_r  <= row_r + 4'd1;
                y_r    <= y_r + 5'd1;
                addr_r <= addr_r + {{(MEM_AW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Moore decode of the memory and framebuffer strobes from the current state.
    always_comb begin
        bus.cmd_ready_out = (state_r == ST_IDLE);
        bus.done_out      = (state_r == ST_DONE);
        bus.collision_out = collision_r;
        bus.mem_rd_out    = (state_r == ST_SPR_RD);
        bus.mem_addr_out  = {MEM_AW{1'b0}};
        bus.fb_rd_out     = 1'b0;
        bus.fb_we_out     = 1'b0;
        bus.fb_addr_out   = {FB_AW{1'b0}};
        bus.fb_wdata_out  = 8'd0;
        case (state_r)
            ST_SPR_RD: bus.mem_addr_out = addr_r;
            ST_FB_RD_L: begin
                bus.fb_rd_out   = 1'b1;
                bus.fb_addr_out = FB_AW'({y_r, x0_r[5:3]});
            end
            ST_FB_WR_L: begin
                bus.fb_we_out    = 1'b1;
                bus.fb_addr_out  = FB_AW'({y_r, x0_r[5:3]});
                bus.fb_wdata_out = bus.fb_data_in ^ mask_l_s;
            end
            ST_FB_RD_R: begin
                bus.fb_rd_out   = 1'b1;
                bus.fb_addr_out = FB_AW'({y_r, x0_r[5:3] + 3'd1});
            end
            ST_FB_WR_R: begin
                bus.fb_we_out    = 1'b1;
                bus.fb_addr_out  = FB_AW'({y_r, x0_r[5:3] + 3'd1});
                bus.fb_wdata_out = bus.fb_data_in ^ mask_r_s;
            end
            ST_CLEAR: begin
                bus.fb_we_out   = 1'b1;
                bus.fb_addr_out = FB_AW'(clr_r);
            end
            default: bus.mem_addr_out = {MEM_AW{1'b0}};
        endcase
    end
endmodule
